bcd_subtractor: RTL and testbench

BCD_SUBTRACTOR -- requirements
Module: bcd_subtractor

---
 rtl/bcd_sub_if.sv | 8 +
 rtl/bcd_subtractor.sv | 86 ++++++++
 tb/tb_bcd_subtractor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_sub_if.sv
// bcd_sub_if: request/result bundle between a requester and bcd_subtractor.
interface bcd_sub_if #(parameter int DIGITS = 3);
  logic                  start;
  logic [4*DIGITS-1:0]   in_1, in_2, out_1;
  logic                  neg, err, busy, done;
  modport master (output start, in_1, in_2, input out_1, neg, err, busy, done);
  modport slave (input start, in_1, in_2, output out_1, neg, err, busy, done);
endinterface

// File: rtl/bcd_subtractor.sv
// bcd_subtractor: digit-serial packed-BCD subtractor, LSD first, one digit per clock.
// BCD_SUB_MAGNITUDE_EN: negative results get a complement pass so out_1 = |in_1 - in_2|.
module bcd_subtractor #(parameter int DIGITS = 3) (
  input logic clk,
  input logic rst_n,
  bcd_sub_if.slave bus
);
  localparam int W = 4*DIGITS;
  localparam logic [1:0] IDLE = 2'd0, SUB = 2'd1;
`ifdef BCD_SUB_MAGNITUDE_EN
  localparam logic [1:0] CPL = 2'd2;
`endif
  logic [1:0] state;
  logic [W-1:0] a, b, res, res_nx;
  logic [3:0] idx, dg;
  logic [4:0] dd;
  logic borrow, bad, in_bad, last, cpl_go, neg_fin;
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      in_bad = in_bad | (bus.in_1[4*i+:4] > 4'd9) | (bus.in_2[4*i+:4] > 4'd9);
    dd = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, borrow};
    dg = dd[4] ? dd[3:0] + 4'd10 : dd[3:0];
    res_nx = (res >> 4) | (W'(dg) << (W-4));
    last = idx == 4'(DIGITS-1);
`ifdef BCD_SUB_MAGNITUDE_EN
    cpl_go = state == SUB && !bad && dd[4];
    neg_fin = !bad && (state == CPL || dd[4]);
`else
    cpl_go = 1'b0;
    neg_fin = !bad && dd[4];
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      res <= '0;
      idx <= '0;
      borrow <= 1'b0;
      bad <= 1'b0;
      bus.out_1 <= '0;
      bus.neg <= 1'b0;
      bus.err <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a <= bus.in_1;
          b <= bus.in_2;
          bad <= in_bad;
          idx <= '0;
          borrow <= 1'b0;
          bus.busy <= 1'b1;
          state <= SUB;
        end
      end else begin
        a <= a >> 4;
        b <= b >> 4;
        res <= res_nx;
        borrow <= dd[4];
        idx <= idx + 4'd1;
        if (last && cpl_go) begin
          // rerun the same digit loop as 0 - raw to recover the magnitude
          a <= '0;
          b <= res_nx;
          idx <= '0;
          borrow <= 1'b0;
`ifdef BCD_SUB_MAGNITUDE_EN
          state <= CPL;
`endif
        end else if (last) begin
          bus.out_1 <= bad ? '0 : res_nx;
          bus.neg <= neg_fin;
          bus.err <= bad;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_subtractor.sv
// tb_bcd_subtractor: directed vector table plus reset/busy/back-to-back sequences.
module tb_bcd_subtractor;
  localparam int DIGITS = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  bcd_sub_if #(.DIGITS(DIGITS)) bus();
  bcd_subtractor #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] a, b, raw, mag;
    logic neg, err;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic go(input logic [11:0] a, input logic [11:0] b);
    bus.start = 1'b1;
    bus.in_1 = a;
    bus.in_2 = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 30) begin
      @(posedge clk);
      #1 n++;
    end
  endtask
  initial begin
    int n;
    logic [11:0] eo;
    int el;
    v[0]  = '{12'h456, 12'h123, 12'h333, 12'h333, 1'b0, 1'b0};
    v[1]  = '{12'h900, 12'h001, 12'h899, 12'h899, 1'b0, 1'b0};
    v[2]  = '{12'h123, 12'h456, 12'h667, 12'h333, 1'b1, 1'b0};
    v[3]  = '{12'h1A3, 12'h001, 12'h000, 12'h000, 1'b0, 1'b1};
    v[4]  = '{12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1'b0};
    v[5]  = '{12'h999, 12'h999, 12'h000, 12'h000, 1'b0, 1'b0};
    v[6]  = '{12'h000, 12'h001, 12'h999, 12'h001, 1'b1, 1'b0};
    v[7]  = '{12'h999, 12'h000, 12'h999, 12'h999, 1'b0, 1'b0};
    v[8]  = '{12'h100, 12'h099, 12'h001, 12'h001, 1'b0, 1'b0};
    v[9]  = '{12'h321, 12'h123, 12'h198, 12'h198, 1'b0, 1'b0};
    v[10] = '{12'h005, 12'hF00, 12'h000, 12'h000, 1'b0, 1'b1};
    v[11] = '{12'h500, 12'h200, 12'h300, 12'h300, 1'b0, 1'b0};
    v[12] = '{12'h250, 12'h750, 12'h500, 12'h500, 1'b1, 1'b0};
    bus.start = 1'b0;
    bus.in_1 = '0;
    bus.in_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_1", 32'(bus.out_1), 0);
    chk("rst neg", 32'(bus.neg), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst done", 32'(bus.done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
`ifdef BCD_SUB_MAGNITUDE_EN
      eo = v[i].mag;
      el = v[i].neg ? 7 : 4;
`else
      eo = v[i].raw;
      el = 4;
`endif
      go(v[i].a, v[i].b);
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 1);
      wait_done(n);
      chk($sformatf("v%0d latency", i), 32'(n), 32'(el));
      chk($sformatf("v%0d out_1", i), 32'(bus.out_1), 32'(eo));
      chk($sformatf("v%0d neg", i), 32'(bus.neg), 32'(v[i].neg));
      chk($sformatf("v%0d err", i), 32'(bus.err), 32'(v[i].err));
      chk($sformatf("v%0d busy@done", i), 32'(bus.busy), 0);
      @(posedge clk);
      #1 chk($sformatf("v%0d done pulse", i), 32'(bus.done), 0);
    end
    go(12'h500, 12'h200);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.in_1 = 12'h777;
    bus.in_2 = 12'h000;
    @(posedge clk);
    #1;
    chk("abort out_1", 32'(bus.out_1), 0);
    chk("abort neg", 32'(bus.neg), 0);
    chk("abort err", 32'(bus.err), 0);
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort done", 32'(bus.done), 0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("start in rst ignored", 32'(bus.busy), 0);
    chk("no done after abort", 32'(bus.done), 0);
    go(12'h000, 12'h000);
    wait_done(n);
    chk("post-rst latency", 32'(n), 4);
    chk("post-rst out_1", 32'(bus.out_1), 0);
    chk("post-rst neg", 32'(bus.neg), 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.in_1 = 12'h456;
    bus.in_2 = 12'h123;
    @(posedge clk);
    #1;
    bus.in_1 = 12'h999;
    bus.in_2 = 12'h111;
    wait_done(n);
    chk("busy-start latency", 32'(n), 4);
    chk("busy-start out_1", 32'(bus.out_1), 32'h333);
    chk("busy-start neg", 32'(bus.neg), 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b accepted busy", 32'(bus.busy), 1);
    chk("b2b done single", 32'(bus.done), 0);
    wait_done(n);
    chk("b2b latency", 32'(n), 4);
    chk("b2b out_1", 32'(bus.out_1), 32'h888);
    chk("b2b neg", 32'(bus.neg), 0);
    chk("b2b err", 32'(bus.err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
